// File: rtl/sum_accum_pkg.sv
// sum_accum_pkg
// Shared definitions for the sum_accum frame accumulator.
// Contents:
//   state_t       - FSM states (ACCUM collects samples, HOLD presents a total)
//   DEF_IN_W      - default sample width (matches the adder stage output)
//   DEF_ACC_W     - default accumulator / total width
//   DEF_FRAME_LEN - default samples per frame
//   cntWidth()    - width of the in-frame sample counter
package sum_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_IN_W      = 5;
  localparam int DEF_ACC_W     = 9;
  localparam int DEF_FRAME_LEN = 16;

  // The counter only has to reach FRAME_LEN-1, so $clog2(FRAME_LEN) bits suffice.
  function automatic int cntWidth(input int frameLen);
    return $clog2(frameLen);
  endfunction

endpackage

// File: rtl/sum_accum_sat_adder.sv
// sat_adder
// Adds a zero-extended unsigned sample to the accumulator and flags any carry
// out of the ACC_W range.
// Build option: SUM_ACCUM_SAT_EN
//   defined   - the sum clamps at 2^ACC_W-1 when it would overflow
//   undefined - the sum wraps modulo 2^ACC_W
// In both builds o_ovf reports that the true result exceeded 2^ACC_W-1.
// Ports:
//   acc   in  ACC_W - current accumulator value
//   din   in  IN_W  - unsigned sample
//   sum   out ACC_W - next accumulator value
//   ovf   out 1     - the true result did not fit in ACC_W bits
module sat_adder #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 9
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] w_full;

  // One extra bit keeps the carry so overflow is exact for any ACC_W >= IN_W.
  assign w_full = {1'b0, acc} + (ACC_W+1)'(din);
  assign ovf    = w_full[ACC_W];

`ifdef SUM_ACCUM_SAT_EN
  // Clamp at full scale; a saturated accumulator stays there for the frame
  // because any further add either overflows again or adds zero.
  assign sum = ovf ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accum.sv
// sum_accum
// Accumulates FRAME_LEN unsigned samples arriving over a valid/ready
// handshake and presents each frame total on a second valid/ready handshake.
// Build option: SUM_ACCUM_SAT_EN (saturating vs wrapping accumulation, see
// sat_adder).
// Ports:
//   clk       in  1     - clock, all state changes on the rising edge
//   rst       in  1     - synchronous active-high reset
//   clear     in  1     - synchronous frame abort
//   in_valid  in  1     - in_data holds a sample
//   in_ready  out 1     - a sample can be accepted (high only in ACCUM)
//   in_data   in  IN_W  - unsigned sample
//   out_valid out 1     - out_sum holds a completed frame total
//   out_ready in  1     - consumer takes the total
//   out_sum   out ACC_W - frame total
//   out_ovf   out 1     - the frame exceeded the ACC_W range
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int                CNT_W    = cntWidth(FRAME_LEN);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovfSticky;
  logic [ACC_W-1:0]   r_outSum;
  logic               r_outOvf;
  logic               r_outValid;

  logic               w_inReady;
  logic               w_accept;
  logic               w_last;
  logic [ACC_W-1:0]   w_sum;
  logic               w_addOvf;

  sat_adder #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_adder (
    .acc (r_acc),
    .din (in_data),
    .sum (w_sum),
    .ovf (w_addOvf)
  );

  // A clear on the same cycle as a sample drops the sample.
  assign w_accept = in_valid && w_inReady && !clear;
  assign w_last   = w_accept && (r_cnt == LAST_CNT);

  // Next-state and ready decode; in_ready depends on state only.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    case (r_state)
      ACCUM: begin
        w_inReady = 1'b1;
        if (w_last) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_nextState = ACCUM;
        end
      end
      default: w_nextState = ACCUM;
    endcase
    if (clear) begin
      w_nextState = ACCUM;
    end
  end

  // State register; out_valid is kept as its own flop so it leaves a register
  // directly rather than through a state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACCUM;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_outValid <= (w_nextState == HOLD);
    end
  end

  // Accumulator, counter, sticky overflow and the held frame result. The
  // sticky bit is folded with the last addition's overflow so the final sample
  // counts, then cleared so the next frame starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovfSticky <= 1'b0;
      r_outSum    <= '0;
      r_outOvf    <= 1'b0;
    end else if (clear) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovfSticky <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_outSum    <= w_sum;
        r_outOvf    <= r_ovfSticky | w_addOvf;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovfSticky <= 1'b0;
      end else begin
        r_acc       <= w_sum;
        r_cnt       <= r_cnt + 1'b1;
        r_ovfSticky <= r_ovfSticky | w_addOvf;
      end
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = r_outValid;
  assign out_sum   = r_outSum;
  assign out_ovf   = r_outOvf;

endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum
// Directed bench for sum_accum. Two instances share all inputs: the default
// configuration (ACC_W=9) and a narrow one (ACC_W=8) whose 16x31 frame
// overflows. Expected narrow-instance totals follow SUM_ACCUM_SAT_EN.
module tb_sum_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [4:0] in_data;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [8:0] out_sum;
  logic       out_ovf;

  logic       in_ready8;
  logic       out_valid8;
  logic [7:0] out_sum8;
  logic       out_ovf8;

  int checks = 0;
  int errors = 0;

`ifdef SUM_ACCUM_SAT_EN
  localparam int EXP_OVF_SUM8 = 255;
`else
  localparam int EXP_OVF_SUM8 = 240;
`endif

  sum_accum #(.IN_W(5), .ACC_W(9), .FRAME_LEN(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  sum_accum #(.IN_W(5), .ACC_W(8), .FRAME_LEN(16)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .in_data   (in_data),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_sum   (out_sum8),
    .out_ovf   (out_ovf8)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input cycle, then step past the edge that samples it.
  task automatic applyStimulus(input logic v, input logic [4:0] d, input logic cl);
    in_valid = v;
    in_data  = d;
    clear    = cl;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_in_ready",  int'(in_ready),  1);
    checkOutput("rst_out_sum",   int'(out_sum),   0);
    checkOutput("rst_out_ovf",   int'(out_ovf),   0);
    checkOutput("rst_out_sum8",  int'(out_sum8),  0);

    // Ramp frame 0..15 with out_ready high: total 120
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("ramp_in_ready", int'(in_ready), 1);
      checkOutput("ramp_no_valid", int'(out_valid), 0);
      applyStimulus(1'b1, 5'(i), 1'b0);
    end
    checkOutput("ramp_out_valid", int'(out_valid), 1);
    checkOutput("ramp_out_sum",   int'(out_sum),   120);
    checkOutput("ramp_out_ovf",   int'(out_ovf),   0);
    checkOutput("ramp_hold_ready", int'(in_ready), 0);
    checkOutput("ramp_out_sum8",  int'(out_sum8),  120);
    checkOutput("ramp_out_ovf8",  int'(out_ovf8),  0);
    tick();
    checkOutput("ramp_valid_1cyc", int'(out_valid), 0);
    checkOutput("ramp_ready_back", int'(in_ready),  1);

    // Back-pressure: 16x31 with out_ready low, held for 10 cycles while a
    // sample of 7 is offered and must be ignored
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 5'd31, 1'b0);
    end
    in_valid = 1'b1;
    in_data  = 5'd7;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_in_ready",  int'(in_ready),  0);
      checkOutput("bp_out_sum",   int'(out_sum),   496);
      tick();
    end
    checkOutput("bp_out_ovf",  int'(out_ovf),  0);
    checkOutput("ovf8_sum",    int'(out_sum8), EXP_OVF_SUM8);
    checkOutput("ovf8_flag",   int'(out_ovf8), 1);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("bp_release_valid", int'(out_valid), 0);
    checkOutput("bp_release_ready", int'(in_ready),  1);

    // Frame of zeros: overflow status must not carry over
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 5'd0, 1'b0);
    end
    checkOutput("zero_out_valid", int'(out_valid), 1);
    checkOutput("zero_out_sum",   int'(out_sum),   0);
    checkOutput("zero_out_sum8",  int'(out_sum8),  0);
    checkOutput("zero_out_ovf8",  int'(out_ovf8),  0);
    tick();

    // clear mid-frame: 7x5, then clear with an 8th sample that is dropped
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 5'd5, 1'b0);
    end
    applyStimulus(1'b1, 5'd5, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("clr_no_valid", int'(out_valid), 0);
      applyStimulus(1'b1, 5'd1, 1'b0);
    end
    checkOutput("clr_out_valid", int'(out_valid), 1);
    checkOutput("clr_out_sum",   int'(out_sum),   16);

    // clear while holding: leave HOLD, keep the last total
    applyStimulus(1'b0, 5'd0, 1'b1);
    checkOutput("clr_hold_valid", int'(out_valid), 0);
    checkOutput("clr_hold_ready", int'(in_ready),  1);
    checkOutput("clr_hold_sum",   int'(out_sum),   16);

    // Mid-frame reset with gaps: 9x3 discarded, then 16x2 gives 32
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 5'd3, 1'b0);
      applyStimulus(1'b0, 5'd0, 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mrst_out_sum", int'(out_sum), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("mrst_no_valid", int'(out_valid), 0);
      applyStimulus(1'b1, 5'd2, 1'b0);
    end
    checkOutput("mrst_out_valid", int'(out_valid), 1);
    checkOutput("mrst_out_sum",   int'(out_sum),   32);
    tick();
    checkOutput("mrst_done_valid", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
# sum_accum

Downstream consumer of the registered 4-bit adder stage: accepts its 5-bit sums one per cycle over a valid/ready handshake, accumulates a frame of `FRAME_LEN` samples, and presents the frame total on a second valid/ready handshake. It sits between the adder datapath and the result/readout logic, converting a per-cycle sum stream into per-frame totals.

## Interface
- `IN_W`, default 5: input sample width, matching the adder stage's output width.
- `ACC_W`, default 9: accumulator and output width.
- `FRAME_LEN`, default 16: samples per frame. Legal range is 2 to 256.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `clear` input, 1 bit: synchronous frame abort.
- `in_valid` input, 1 bit: the sample on `in_data` is valid.
- `in_ready` output, 1 bit: the block can accept a sample.
- `in_data` input, `IN_W` bits: unsigned sample.
- `out_valid` output, 1 bit: `out_sum` holds a completed frame total.
- `out_ready` input, 1 bit: the consumer takes the total.
- `out_sum` output, `ACC_W` bits: frame total.
- `out_ovf` output, 1 bit: the frame exceeded the `ACC_W` range.

## Operation
- **States:** ACCUM and HOLD.
- **Reset:** on `rst`, state goes to ACCUM; `acc`, `cnt`, `out_sum`, `out_ovf` and `out_valid` all go to 0.
- **ACCUM behaviour:**
  - `in_ready` = 1 and `out_valid` = 0.
  - A sample is accepted on a cycle with `in_valid && in_ready`.
  - On acceptance, `acc <= acc + in_data` (zero-extended) and `cnt <= cnt + 1`.
- **End of frame:**
  - When a sample is accepted with `cnt == FRAME_LEN-1`, `out_sum` is loaded with `acc + in_data` and `out_ovf` is loaded with the frame overflow status.
  - In the same edge, `acc` and `cnt` return to 0 and state goes to HOLD.
- **HOLD behaviour:**
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_sum` and `out_ovf` are stable until the total is taken.
  - On `out_ready`, state returns to ACCUM.
- **Overflow:** any addition whose true result exceeds 2^`ACC_W`−1 sets a frame-sticky overflow bit. That bit is copied to `out_ovf` at end of frame and cleared when the next frame starts.
- **`clear`:** in either state, resets `acc`, `cnt` and the sticky bit, and forces state to ACCUM with `out_valid` = 0. `out_sum` and `out_ovf` keep their last value.
- **Simultaneous events:**
  - `clear` together with `in_valid` in ACCUM: `clear` wins and the sample is dropped.
  - `clear` together with `out_ready` in HOLD: same result, return to ACCUM.
  - `rst` overrides everything.
- **Idle input:** `in_valid` low for any number of cycles in ACCUM holds all state unchanged.

## Timing
- **Input:** `in_ready` is a pure function of state (combinational); it does not depend on `in_valid` or `out_ready`.
- **Output registering:** `out_valid`, `out_sum` and `out_ovf` are registered.
- **Latency:** `out_valid` rises on the edge that accepts the last sample, so it is visible one cycle after that sample is presented.
- **Throughput:**
  - A frame takes at least `FRAME_LEN` accepting cycles, plus at least one HOLD cycle.
  - With `out_ready` held high, HOLD lasts exactly one cycle, giving `FRAME_LEN`+1 cycles per frame.
- **Back-pressure:** HOLD persists indefinitely while `out_ready` = 0, and no samples are accepted during that time.
- **Mid-frame reset:** a reset asserted during a frame takes effect on the next edge. The partial frame is discarded and never presented.

## Configuration
- **`SUM_ACCUM_SAT_EN` defined:**
  - Each addition saturates at 2^`ACC_W`−1.
  - Once saturated, `acc` stays at the maximum for the rest of the frame.
  - `out_ovf` reports whether saturation occurred.
- **`SUM_ACCUM_SAT_EN` undefined:**
  - Additions wrap modulo 2^`ACC_W`.
  - `out_ovf` still reports that a wrap occurred.
- **Default widths:** with the default parameters, no overflow is possible. The worst case is 16×31 = 496, which is below 511.

## Structure
- **Package `sum_accum_pkg`:**
  - State enum (ACCUM, HOLD).
  - Default `IN_W`, `ACC_W` and `FRAME_LEN` localparams.
  - A function computing the `cnt` width, $clog2(`FRAME_LEN`).
- **Sub-module `sat_adder`:**
  - Inputs: `ACC_W`-bit accumulator and `IN_W`-bit sample.
  - Outputs: `ACC_W`-bit sum and an overflow bit.
  - Saturate vs wrap is selected by `SUM_ACCUM_SAT_EN`.
- **Top level:** holds the FSM, the counter and the output registers.

## Test plan
- **Reset values:** hold `rst` for 2 cycles → `out_valid`=0, `in_ready`=1, `out_sum`=0, `out_ovf`=0.
- **Ramp frame:** with `out_ready`=1, feed 0..15 on consecutive cycles → `out_valid` for exactly 1 cycle with `out_sum`=120 and `out_ovf`=0, then `in_ready`=1 on the next cycle.
- **Back-pressure:** feed 16 samples of 31 with `out_ready`=0 → `out_sum`=496 is held and `in_ready`=0 for 10 cycles. Raise `out_ready` → return to ACCUM on the following edge.
- **Overflow (`ACC_W`=8, 16 samples of 31):**
  - `SUM_ACCUM_SAT_EN` defined → `out_sum`=255, `out_ovf`=1.
  - `SUM_ACCUM_SAT_EN` undefined → `out_sum`=240, `out_ovf`=1.
  - The next frame of 16 zeros → `out_sum`=0, `out_ovf`=0.
- **`clear` mid-frame:**
  - Feed 7 samples of 5.
  - Pulse `clear` together with an 8th sample of 5 → that sample is dropped.
  - Then feed 16 samples of 1 → `out_sum`=16.
- **Mid-frame reset with gaps:**
  - Feed 9 samples of 3 with `in_valid` gaps, then assert `rst`.
  - Then feed 16 samples of 2 → `out_sum`=32.
  - No `out_valid` appears before that frame completes.
